fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequences the combinational, word-addressed instruction memory (256 x 32, `instruction = memory[address]`): owns the PC and drives the memory address.
- Captures each fetched word into a one-entry output register with a valid/ready handshake to decode.
- Stops fetching after the HALT opcode (instruction[31:24] == 8'h60).
- Accepts PC redirects from execute (branch/jump) and counts delivered fetches.

Parameters:
- ADDR_W, 8, PC width; memory depth 2^ADDR_W words; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded by reset.
- HALT_OPCODE, 8'h60, opcode in bits [31:24] that stops fetch.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- imem_address  out  32  word address to instruction memory; {zeros, pc}.
- imem_instruction  in  32  combinational read data from instruction memory.
- redirect_valid  in  1  one-cycle request to load a new PC.
- redirect_target  in  ADDR_W  new PC value.
- out_valid  out  1  out_instruction/out_pc hold a fetched word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_instruction  out  32  fetched instruction.
- out_pc  out  ADDR_W  address it was fetched from.
- halted  out  1  state == HALTED.
- busy  out  1  state == RUN.
- fetch_count  out  32  words captured since reset; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, out_valid=0, out_instruction=0, out_pc=0, fetch_count=0, halted=0, busy=0. Reset mid-fetch discards the output register contents.
- imem_address = zero-extended pc, combinational from the pc register in every state.
- advance = out_valid==0 || out_ready==1.
- States: IDLE, RUN, HALTED.
- IDLE:
  - start=1 -> RUN next cycle; no capture in that cycle.
  - redirect_valid=1 loads pc=redirect_target and stays in IDLE.
  - If start and redirect_valid are both 1, both take effect.
- RUN, advance=1 and redirect_valid=0:
  - out_instruction<=imem_instruction, out_pc<=pc, out_valid<=1, fetch_count++.
  - If imem_instruction[31:24]==HALT_OPCODE: state<=HALTED, pc unchanged. Otherwise pc<=pc+1, wrapping from 2^ADDR_W-1 to 0.
  - Throughput: 1 word/cycle while out_ready=1.
  - Latency: address to out_valid is 1 cycle.
- RUN, advance=0: all registers hold. The consumer sees stable data while out_valid=1 and out_ready=0.
- HALTED:
  - No captures.
  - A pending output word, which is the HALT word itself, drains normally: out_valid<=0 when out_ready=1.
  - start is ignored.
- Redirect in RUN or HALTED:
  - redirect_valid=1 has priority over capture: out_valid<=0 (word flushed, even if out_ready=1 that cycle), pc<=redirect_target, state<=RUN.
  - fetch_count does not increment in that cycle.
  - The first word at the target is captured the following cycle.
- Handshake: a word transfers when out_valid&&out_ready at the clock edge. With out_ready=1 and a new capture in the same cycle, the old word transfers and the new one replaces it; no bubble.
- HALT at the wrap address 2^ADDR_W-1: pc stays at 2^ADDR_W-1.
- No X propagation: all outputs are registered or derived from registers, except imem_address (from pc).

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, HALTED=2'd2);
  - OPCODE_HALT=8'h60, plus the existing opcode constants 8'h23, 8'h28, 8'h2a;
  - the INSTR_W=32 constant.
- One natural sub-module: fetch_output_reg.
  - Holds the one-entry valid/ready register with load, flush and hold.
  - The FSM, PC and counter stay in fetch_controller.

Test Plan:
- Straight-line to halt:
  - Stimulus: memory {0x23000001, 0x28000002, 0x2a000003, 0x60000004}, reset, start, out_ready=1.
  - Required: out_pc 0,1,2,3 on consecutive cycles with the matching words; halted=1 one cycle after the pc=3 capture; pc stays 3; fetch_count=4.
- Backpressure:
  - Stimulus: same program, out_ready=0 for 3 cycles after the first capture.
  - Required: out_instruction holds 0x23000001 and imem_address holds 1 for 3 cycles; then words 1..3 follow with no loss or duplication.
- Redirect priority:
  - Stimulus: in RUN at pc=2, assert redirect_valid with target 0 while out_valid=1 and out_ready=1.
  - Required: out_valid=0 the next cycle; fetch_count unchanged that cycle; the next capture is out_pc=0 with 0x23000001.
- Restart from HALTED:
  - Stimulus: after halt, pulse start, then pulse redirect with target 1.
  - Required: start has no effect; after the redirect, busy=1 and fetch resumes at 0x28000002 up to HALT again.
- Wrap-around:
  - Stimulus: ADDR_W=8, redirect to 255, memory[255]=0x23000000, memory[0]=0x60000004.
  - Required: out_pc 255 then 0; halt at 0.
- Async reset mid-run:
  - Stimulus: assert reset between clock edges while out_valid=1.
  - Required: out_valid=0, pc=0, fetch_count=0, state=IDLE immediately, before the next clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, opcode constants and word width.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam logic [7:0] OPCODE_LW   = 8'h23;
    localparam logic [7:0] OPCODE_SB   = 8'h28;
    localparam logic [7:0] OPCODE_SLT  = 8'h2a;
    localparam logic [7:0] OPCODE_HALT = 8'h60;

endpackage

// File: rtl/fetch_output_reg.sv
// One-entry valid/ready output register: load replaces, flush empties, otherwise
// the word holds until the consumer takes it.
module fetch_output_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_flush,
    input  logic               i_ready,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    // Flush wins over load; a transferred word with no replacement leaves the register empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives the instruction memory address,
// captures words for decode, stops on HALT and accepts redirects from execute.
module fetch_controller
    import cpu_pkg::*;
#(
    parameter int unsigned      ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [7:0]       HALT_OPCODE = OPCODE_HALT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [31:0]        imem_address,
    input  logic [INSTR_W-1:0] imem_instruction,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instruction,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic               busy,
    output logic [31:0]        fetch_count
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [31:0]        r_fetch_count;
    logic               w_load;
    logic               w_flush;
    logic               w_advance;
    logic               w_is_halt;
    logic               w_out_valid;

    assign w_advance = !w_out_valid || out_ready;
    assign w_is_halt = (imem_instruction[INSTR_W-1 -: 8] == HALT_OPCODE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_load && (r_fetch_count != '1)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    // Next state, next PC and capture control; a redirect outranks any capture.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
                if (redirect_valid) begin
                    w_pc_nxt = redirect_target;
                end
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    w_flush  = 1'b1;
                    w_pc_nxt = redirect_target;
                end else if (w_advance) begin
                    w_load = 1'b1;
                    if (w_is_halt) begin
                        w_state_nxt = ST_HALTED;
                    end else begin
                        w_pc_nxt = r_pc + ADDR_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    w_flush     = 1'b1;
                    w_pc_nxt    = redirect_target;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    fetch_output_reg #(
        .ADDR_W (ADDR_W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_ready (out_ready),
        .i_instr (imem_instruction),
        .i_pc    (r_pc),
        .o_valid (w_out_valid),
        .o_instr (out_instruction),
        .o_pc    (out_pc)
    );

    assign imem_address = 32'(r_pc);
    assign out_valid    = w_out_valid;
    assign halted       = (r_state == ST_HALTED);
    assign busy         = (r_state == ST_RUN);
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: directed programs push expected words,
// a negedge monitor pops and compares every transferred word.
module tb_fetch_controller;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_target = 8'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [7:0]  out_pc;
    logic        halted;
    logic        busy;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];
    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign imem_instruction = mem[imem_address[7:0]];

    fetch_controller dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .halted           (halted),
        .busy             (busy),
        .fetch_count      (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h23000001;
        mem[1] = 32'h28000002;
        mem[2] = 32'h2a000003;
        mem[3] = 32'h60000004;
    endtask

    task automatic push(input logic [7:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Steps until halted, returning the number of cycles taken; an expired bound is a failure.
    task automatic wait_halt(input string name, input int bound, output int cyc);
        cyc = 0;
        while (!halted && cyc < bound) begin
            step();
            cyc++;
        end
        n_checks++;
        if (!halted) begin
            n_fail++;
            $display("FAIL %s: halt not seen within %0d cycles", name, bound);
        end
    endtask

    // A word transfers on valid && ready unless a redirect flushes it the same cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready && !redirect_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc=%0d instr=0x%08h, required no word", out_pc, out_instruction);
                end else begin
                    e = q.pop_front();
                    chk("sb_pc", 32'(out_pc), 32'(e.pc));
                    chk("sb_instr", out_instruction, e.instr);
                end
            end
        end
    end

    initial begin
        int cyc;
        load_prog();
        do_reset();

        // Reset state and straight-line run to HALT
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", imem_address, 32'd0);
        chk("rst_instr", out_instruction, 32'd0);
        out_ready = 1'b1;
        push(8'd0, 32'h23000001);
        push(8'd1, 32'h28000002);
        push(8'd2, 32'h2a000003);
        push(8'd3, 32'h60000004);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_no_capture", 32'(out_valid), 32'd0);
        wait_halt("t1_halt", 20, cyc);
        chk("t1_halt_cycles", 32'(cyc), 32'd4);
        chk("t1_halt_pc", 32'(out_pc), 32'd3);
        chk("t1_addr", imem_address, 32'd3);
        chk("t1_count", fetch_count, 32'd4);
        step();
        step();
        chk("t1_drained", 32'(out_valid), 32'd0);
        chk("t1_addr_hold", imem_address, 32'd3);
        chk("t1_q_empty", 32'(q.size()), 32'd0);

        // Backpressure after first capture
        out_ready = 1'b0;
        do_reset();
        push(8'd0, 32'h23000001);
        push(8'd1, 32'h28000002);
        push(8'd2, 32'h2a000003);
        push(8'd3, 32'h60000004);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("bp_instr", out_instruction, 32'h23000001);
            chk("bp_addr", imem_address, 32'd1);
            step();
        end
        out_ready = 1'b1;
        wait_halt("t2_halt", 20, cyc);
        step();
        step();
        chk("t2_count", fetch_count, 32'd4);
        chk("t2_q_empty", 32'(q.size()), 32'd0);

        // Redirect priority over capture and handshake
        do_reset();
        push(8'd0, 32'h23000001);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("t3_pre_addr", imem_address, 32'd2);
        chk("t3_pre_valid", 32'(out_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_target = 8'd0;
        push(8'd0, 32'h23000001);
        push(8'd1, 32'h28000002);
        push(8'd2, 32'h2a000003);
        push(8'd3, 32'h60000004);
        step();
        redirect_valid = 1'b0;
        chk("t3_flush_valid", 32'(out_valid), 32'd0);
        chk("t3_count_held", fetch_count, 32'd2);
        chk("t3_addr", imem_address, 32'd0);
        wait_halt("t3_halt", 20, cyc);
        chk("t3_count", fetch_count, 32'd6);
        step();
        step();

        // Start ignored in HALTED, redirect resumes
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t4_still_halted", 32'(halted), 32'd1);
        chk("t4_not_busy", 32'(busy), 32'd0);
        chk("t4_addr", imem_address, 32'd3);
        chk("t4_count", fetch_count, 32'd6);
        redirect_valid = 1'b1;
        redirect_target = 8'd1;
        push(8'd1, 32'h28000002);
        push(8'd2, 32'h2a000003);
        push(8'd3, 32'h60000004);
        step();
        redirect_valid = 1'b0;
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_valid", 32'(out_valid), 32'd0);
        wait_halt("t4_halt", 20, cyc);
        chk("t4_count_end", fetch_count, 32'd9);
        step();
        step();
        chk("t4_q_empty", 32'(q.size()), 32'd0);

        // PC wrap from 255 to 0, start and redirect together in IDLE
        mem[255] = 32'h23000000;
        mem[0] = 32'h60000004;
        do_reset();
        push(8'd255, 32'h23000000);
        push(8'd0, 32'h60000004);
        start = 1'b1;
        redirect_valid = 1'b1;
        redirect_target = 8'd255;
        step();
        start = 1'b0;
        redirect_valid = 1'b0;
        chk("t5_addr", imem_address, 32'd255);
        chk("t5_busy", 32'(busy), 32'd1);
        wait_halt("t5_halt", 20, cyc);
        chk("t5_halt_addr", imem_address, 32'd0);
        chk("t5_count", fetch_count, 32'd2);
        step();
        step();
        chk("t5_q_empty", 32'(q.size()), 32'd0);

        // Asynchronous reset between edges with a word held
        load_prog();
        out_ready = 1'b0;
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_addr", imem_address, 32'd0);
        chk("t6_count", fetch_count, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_halted", 32'(halted), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("t6_idle_valid", 32'(out_valid), 32'd0);
        chk("t6_q_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
